// File: rtl/ss_find_min_swap.sv
// ss_find_min_swap
// Selection-sort compare/swap stage sitting after the RAM read stage.
// During one pass over addresses si..ei it watches the in-order read stream,
// tracks the extreme value (min when ASCEND=1, max when ASCEND=0) and its
// address, then swaps that value with the one at si by two RAM writes and
// pulses o_done to the sort controller.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_start, i_si_ram         start pulse and pass start address
//   i_data_valid, i_data      read stream beats, address order si, si+1, ...
//   i_done_read               read stage finished the pass
//   o_we_ram/o_waddr_ram/o_wdata_ram   RAM write port (swap write-back)
//   o_min_data, o_min_addr    selected extreme and its address
//   o_swap                    last pass performed a swap
//   o_done                    one-cycle pass-complete pulse
//   o_busy                    FSM not idle
module ss_find_min_swap #(
  parameter int SIZE_ADDR = 6,
  parameter int SIZE_DATA = 8,
  parameter bit ASCEND    = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [SIZE_ADDR-1:0] i_si_ram,
  input  logic                 i_data_valid,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic                 i_done_read,
  output logic                 o_we_ram,
  output logic [SIZE_ADDR-1:0] o_waddr_ram,
  output logic [SIZE_DATA-1:0] o_wdata_ram,
  output logic [SIZE_DATA-1:0] o_min_data,
  output logic [SIZE_ADDR-1:0] o_min_addr,
  output logic                 o_swap,
  output logic                 o_done,
  output logic                 o_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    WR_SI  = 3'd2,
    WR_MIN = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [SIZE_ADDR-1:0] ADDR_ZERO = {SIZE_ADDR{1'b0}};
  localparam logic [SIZE_ADDR-1:0] ADDR_ONE  = {{(SIZE_ADDR-1){1'b0}}, 1'b1};
  localparam logic [SIZE_DATA-1:0] DATA_ZERO = {SIZE_DATA{1'b0}};

  state_t               state_q, state_d;
  logic [SIZE_ADDR-1:0] si_q, si_d;
  logic [SIZE_ADDR-1:0] cnt_addr_q, cnt_addr_d;
  logic [SIZE_ADDR-1:0] min_addr_q, min_addr_d;
  logic [SIZE_DATA-1:0] min_data_q, min_data_d;
  logic [SIZE_DATA-1:0] first_data_q, first_data_d;
  logic                 first_q, first_d;
  logic                 swap_q, swap_d;
  logic                 we_q, we_d;
  logic [SIZE_ADDR-1:0] waddr_q, waddr_d;
  logic [SIZE_DATA-1:0] wdata_q, wdata_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  // Strict compare: ties keep the earlier address (stable selection).
  function automatic logic is_better(input logic [SIZE_DATA-1:0] cand,
                                     input logic [SIZE_DATA-1:0] best);
    if (ASCEND) begin
      return (cand < best);
    end else begin
      return (cand > best);
    end
  endfunction

  // Next-state and datapath update for the scan/swap sequence.
  always_comb begin
    state_d      = state_q;
    si_d         = si_q;
    cnt_addr_d   = cnt_addr_q;
    min_addr_d   = min_addr_q;
    min_data_d   = min_data_q;
    first_data_d = first_data_q;
    first_d      = first_q;
    swap_d       = swap_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          si_d       = i_si_ram;
          cnt_addr_d = i_si_ram;
          first_d    = 1'b1;
          min_addr_d = ADDR_ZERO;
          min_data_d = DATA_ZERO;
          swap_d     = 1'b0;
          state_d    = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (i_data_valid) begin
          cnt_addr_d = cnt_addr_q + ADDR_ONE;
          first_d    = 1'b0;
          if (first_q) begin
            first_data_d = i_data;
            min_data_d   = i_data;
            min_addr_d   = cnt_addr_q;
          end else if (is_better(i_data, min_data_q)) begin
            min_data_d = i_data;
            min_addr_d = cnt_addr_q;
          end else begin
            min_data_d = min_data_q;
          end
        end else begin
          cnt_addr_d = cnt_addr_q;
        end
        // Exit uses the post-beat values so a beat coincident with
        // i_done_read still takes part in the selection.
        if (i_done_read) begin
          if (first_d) begin
            state_d = DONE;
          end else if (min_addr_d == si_q) begin
            state_d = DONE;
          end else begin
            state_d = WR_SI;
          end
        end else begin
          state_d = SCAN;
        end
      end
      WR_SI: begin
        state_d = WR_MIN;
      end
      WR_MIN: begin
        swap_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output next values derived from the next state so outputs are registered
  // yet aligned with the state they belong to.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = ADDR_ZERO;
    wdata_d = DATA_ZERO;
    case (state_d)
      WR_SI: begin
        we_d    = 1'b1;
        waddr_d = si_d;
        wdata_d = min_data_d;
      end
      WR_MIN: begin
        we_d    = 1'b1;
        waddr_d = min_addr_d;
        wdata_d = first_data_d;
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      si_q         <= ADDR_ZERO;
      cnt_addr_q   <= ADDR_ZERO;
      min_addr_q   <= ADDR_ZERO;
      min_data_q   <= DATA_ZERO;
      first_data_q <= DATA_ZERO;
      first_q      <= 1'b0;
      swap_q       <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= ADDR_ZERO;
      wdata_q      <= DATA_ZERO;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      si_q         <= si_d;
      cnt_addr_q   <= cnt_addr_d;
      min_addr_q   <= min_addr_d;
      min_data_q   <= min_data_d;
      first_data_q <= first_data_d;
      first_q      <= first_d;
      swap_q       <= swap_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign o_we_ram    = we_q;
  assign o_waddr_ram = waddr_q;
  assign o_wdata_ram = wdata_q;
  assign o_min_data  = min_data_q;
  assign o_min_addr  = min_addr_q;
  assign o_swap      = swap_q;
  assign o_done      = done_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_ss_find_min_swap.sv
// Bench for ss_find_min_swap: one ascending and one descending instance share
// the same stimulus; each pass is compared against a simple selection model.
module tb_ss_find_min_swap;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic [5:0] si_in   = 6'd0;
  logic       dv      = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       done_rd = 1'b0;

  logic [1:0] we_s, swap_s, done_s, busy_s;
  logic [5:0] waddr_s [2];
  logic [5:0] maddr_s [2];
  logic [7:0] wdata_s [2];
  logic [7:0] mdata_s [2];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  // Monitor log, written only by the monitor process.
  logic [13:0] wr [2][256];
  int          wr_n   [2] = '{0, 0};
  int          done_n [2] = '{0, 0};
  int          done_c [2] = '{0, 0};

  int bq[$];

  ss_find_min_swap #(.SIZE_ADDR(6), .SIZE_DATA(8), .ASCEND(1'b1)) dut_asc (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_si_ram(si_in),
    .i_data_valid(dv), .i_data(data_in), .i_done_read(done_rd),
    .o_we_ram(we_s[0]), .o_waddr_ram(waddr_s[0]), .o_wdata_ram(wdata_s[0]),
    .o_min_data(mdata_s[0]), .o_min_addr(maddr_s[0]), .o_swap(swap_s[0]),
    .o_done(done_s[0]), .o_busy(busy_s[0]));

  ss_find_min_swap #(.SIZE_ADDR(6), .SIZE_DATA(8), .ASCEND(1'b0)) dut_desc (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_si_ram(si_in),
    .i_data_valid(dv), .i_data(data_in), .i_done_read(done_rd),
    .o_we_ram(we_s[1]), .o_waddr_ram(waddr_s[1]), .o_wdata_ram(wdata_s[1]),
    .o_min_data(mdata_s[1]), .o_min_addr(maddr_s[1]), .o_swap(swap_s[1]),
    .o_done(done_s[1]), .o_busy(busy_s[1]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record RAM writes and done pulses on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (we_s[i]) begin
        if (wr_n[i] < 256) wr[i][wr_n[i]] <= {waddr_s[i], wdata_s[i]};
        wr_n[i] <= wr_n[i] + 1;
      end
      if (done_s[i]) begin
        done_n[i] <= done_n[i] + 1;
        done_c[i] <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One pass: start at si, stream bq, finish with done (optionally on the
  // last beat), optionally pulse start mid-scan; then check both instances.
  task automatic run_pass(input logic [5:0] si, input bit with_last, input bit inject, input string name);
    int base_w [2];
    int base_d [2];
    int n;
    int drv_cyc;
    int ng;
    for (int i = 0; i < 2; i++) begin
      base_w[i] = wr_n[i];
      base_d[i] = done_n[i];
    end
    n = bq.size();
    start = 1'b1;
    si_in = si;
    step();
    start = 1'b0;
    drv_cyc = cyc;
    for (int j = 0; j < n; j++) begin
      ng = int'($urandom_range(0, 2));
      if (inject && j == 1) ng = 1;
      for (int g = 0; g < ng; g++) begin
        if (inject && j == 1 && g == 0) begin
          start = 1'b1;
          si_in = ~si;
        end
        step();
        start = 1'b0;
      end
      dv = 1'b1;
      data_in = 8'(bq[j]);
      if (with_last && j == n - 1) begin
        done_rd = 1'b1;
        drv_cyc = cyc;
      end
      step();
      dv = 1'b0;
      done_rd = 1'b0;
    end
    if (!(with_last && n > 0)) begin
      done_rd = 1'b1;
      drv_cyc = cyc;
      step();
      done_rd = 1'b0;
    end
    for (int t = 0; t < 8 && !(done_n[0] > base_d[0] && done_n[1] > base_d[1]); t++) step();
    chk({name, " timeout"}, 32'(done_n[0] > base_d[0] && done_n[1] > base_d[1]), 32'd1);
    for (int t = 0; t < 3; t++) step();

    for (int i = 0; i < 2; i++) begin
      int idx;
      int exp_nw;
      int exp_lat;
      logic [7:0] em_data;
      logic [5:0] em_addr;
      logic       e_swap;
      string tg;
      tg = $sformatf("%s[%s]", name, (i == 0) ? "asc" : "desc");
      idx = 0;
      for (int j = 1; j < n; j++) begin
        if (i == 0 ? (bq[j] < bq[idx]) : (bq[j] > bq[idx])) idx = j;
      end
      if (n == 0) begin
        em_data = 8'd0;
        em_addr = 6'd0;
        e_swap  = 1'b0;
      end else begin
        em_data = 8'(bq[idx]);
        em_addr = si + 6'(idx);
        e_swap  = (idx != 0);
      end
      exp_nw  = e_swap ? 2 : 0;
      exp_lat = e_swap ? 3 : 1;
      chk({tg, " done_pulses"}, 32'(done_n[i] - base_d[i]), 32'd1);
      chk({tg, " latency"}, 32'(done_c[i] - drv_cyc), 32'(exp_lat));
      chk({tg, " n_writes"}, 32'(wr_n[i] - base_w[i]), 32'(exp_nw));
      if (e_swap && wr_n[i] - base_w[i] == 2) begin
        chk({tg, " write_si"}, 32'(wr[i][base_w[i]]), 32'({si, em_data}));
        chk({tg, " write_min"}, 32'(wr[i][base_w[i] + 1]), 32'({em_addr, 8'(bq[0])}));
      end
      chk({tg, " min_data"}, 32'(mdata_s[i]), 32'(em_data));
      chk({tg, " min_addr"}, 32'(maddr_s[i]), 32'(em_addr));
      chk({tg, " swap"}, 32'(swap_s[i]), 32'(e_swap));
      chk({tg, " busy_idle"}, 32'(busy_s[i]), 32'd0);
    end
  endtask

  initial begin
    int bw;
    int bd;
    int n;
    int hi;
    // Reset state.
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      chk("rst we", 32'(we_s[i]), 32'd0);
      chk("rst waddr", 32'(waddr_s[i]), 32'd0);
      chk("rst wdata", 32'(wdata_s[i]), 32'd0);
      chk("rst min_data", 32'(mdata_s[i]), 32'd0);
      chk("rst min_addr", 32'(maddr_s[i]), 32'd0);
      chk("rst swap", 32'(swap_s[i]), 32'd0);
      chk("rst done", 32'(done_s[i]), 32'd0);
      chk("rst busy", 32'(busy_s[i]), 32'd0);
    end
    rst_n = 1'b1;
    step();

    // Inputs ignored in IDLE.
    dv = 1'b1; data_in = 8'd1; done_rd = 1'b1;
    step();
    dv = 1'b0; done_rd = 1'b0;
    step();
    chk("idle_ignore done", 32'(done_n[0] + done_n[1]), 32'd0);
    chk("idle_ignore busy", 32'(busy_s), 32'd0);

    bq = '{9, 4, 7, 4, 8};  run_pass(6'd0, 1'b0, 1'b0, "tie");
    bq = '{2, 5, 6};        run_pass(6'd10, 1'b0, 1'b0, "noswap");
    bq = '{1, 8, 8, 3};     run_pass(6'd3, 1'b0, 1'b0, "desc_tie");
    bq = '{6, 7, 9, 0};     run_pass(6'd2, 1'b1, 1'b0, "last_with_done");
    bq = '{5, 3, 1};        run_pass(6'd62, 1'b0, 1'b0, "wrap");
    bq = {};                run_pass(6'd7, 1'b0, 1'b0, "zero_beats");
    bq = '{5, 2, 9, 1};     run_pass(6'd20, 1'b0, 1'b1, "start_in_scan");

    for (int r = 0; r < 25; r++) begin
      bq = {};
      n = int'($urandom_range(0, 8));
      hi = ($urandom_range(0, 1) == 0) ? 7 : 255;
      for (int j = 0; j < n; j++) bq.push_back(int'($urandom_range(0, hi)));
      run_pass(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $sformatf("rand%0d", r));
    end

    // Reset asserted during WR_SI aborts the swap.
    bq = '{9, 4};
    start = 1'b1; si_in = 6'd0;
    step();
    start = 1'b0;
    dv = 1'b1; data_in = 8'd9; step();
    data_in = 8'd4; step();
    dv = 1'b0; done_rd = 1'b1; step();
    done_rd = 1'b0;
    for (int t = 0; t < 6 && !we_s[0]; t++) step();
    chk("rst_abort we_seen", 32'(we_s[0]), 32'd1);
    chk("rst_abort wr_si_addr", 32'(waddr_s[0]), 32'd0);
    chk("rst_abort wr_si_data", 32'(wdata_s[0]), 32'd4);
    bw = wr_n[0];
    bd = done_n[0];
    rst_n = 1'b0;
    #1;
    chk("rst_abort we_low", 32'(we_s[0]), 32'd0);
    chk("rst_abort busy_low", 32'(busy_s[0]), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) step();
    chk("rst_abort no_wr_min", 32'(wr_n[0] - bw), 32'd0);
    chk("rst_abort no_done", 32'(done_n[0] - bd), 32'd0);
    chk("rst_abort idle", 32'(busy_s[0]), 32'd0);
    chk("rst_abort swap", 32'(swap_s[0]), 32'd0);

    // A normal pass still works after the abort.
    bq = '{3, 1, 2};
    run_pass(6'd40, 1'b0, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
